// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_pkg
// Brief   : Shared op codes, FSM states and default width for the HI/LO unit.
// Revision: 1.0 - initial release
// ============================================================================
package hilo_pkg;

    localparam int c_HILO_WIDTH = 32;

    typedef enum logic [2:0] {
        HILO_MULTU = 3'b000,
        HILO_MULT  = 3'b001,
        HILO_DIVU  = 3'b010,
        HILO_DIV   = 3'b011,
        HILO_MTHI  = 3'b100,
        HILO_MTLO  = 3'b101
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } hilo_state_e;

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op[2:1] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_div_iter.sv
`default_nettype none
// ============================================================================
// Module  : hilo_div_iter
// Brief   : One restoring-division step: shift in a dividend bit, trial
//           subtract, keep or restore the remainder, emit one quotient bit.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_div_iter
    import hilo_pkg::*;
#(
    parameter int WIDTH = c_HILO_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_shift = {rem_in, quo_in[WIDTH-1]};
        w_diff  = w_shift - {1'b0, divisor};
        // Remainder stays below the divisor, so the top bit of the trial
        // difference is a clean borrow flag.
        if (!w_diff[WIDTH]) begin
            rem_out = w_diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = w_shift[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv
// Brief   : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
//           Divider present only when HILO_DIV_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = c_HILO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int c_CNT_W = ($clog2(WIDTH + 1) > 5) ? $clog2(WIDTH + 1) : 5;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    hilo_state_e          r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_op_mul;
    logic                 w_op_run;
    logic                 w_sgn_op;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_step_next;
    logic [2*WIDTH-1:0]   w_prod_fix;

    assign w_op_mul = op_is_mul(op);
    assign w_sgn_op = ~op[2] & op[0];
    assign w_sa     = w_sgn_op & a[WIDTH-1];
    assign w_sb     = w_sgn_op & b[WIDTH-1];
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;

    // Shift-add: the multiplier sits in the low half and drains one bit per cycle.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

`ifdef HILO_DIV_EN
    logic             r_is_div;
    logic             r_div0;
    logic             r_dbz;
    logic [WIDTH-1:0] r_a_raw;
    logic             w_op_div;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_op_div = (op[2:1] == 2'b01);
    assign w_op_run = w_op_mul | w_op_div;

    hilo_div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .rem_in  (r_acc[2*WIDTH-1:WIDTH]),
        .quo_in  (r_acc[WIDTH-1:0]),
        .divisor (r_opnd),
        .rem_out (w_div_rem),
        .quo_out (w_div_quo)
    );

    assign w_step_next = r_is_div ? {w_div_rem, w_div_quo} : w_mul_next;
    assign w_quo_fix   = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix   = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign div_by_zero = r_dbz;
`else
    assign w_op_run    = w_op_mul;
    assign w_step_next = w_mul_next;
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef HILO_DIV_EN
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_dbz    <= 1'b0;
            r_a_raw  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && w_op_run) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= c_CNT_INIT;
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        if (w_op_mul) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            r_opnd <= w_abs_a;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            r_opnd <= w_abs_b;
                        end
`ifdef HILO_DIV_EN
                        r_is_div <= w_op_div;
                        r_div0   <= (b == '0);
                        r_a_raw  <= a;
                        r_dbz    <= 1'b0;
`endif
                    end else if (start && (op == HILO_MTHI)) begin
                        r_hi <= a;
                    end else if (start && (op == HILO_MTLO)) begin
                        r_lo <= a;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_step_next;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
`ifdef HILO_DIV_EN
                    if (r_is_div) begin
                        r_dbz <= r_div0;
                        r_hi  <= r_div0 ? r_a_raw : w_rem_fix;
                        r_lo  <= r_div0 ? {WIDTH{1'b1}} : w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
`else
                    {r_hi, r_lo} <= w_prod_fix;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_hilo_muldiv
// Brief   : Self-checking bench for hilo_muldiv (WIDTH=32): directed vectors,
//           busy/abort corner sequences and randomized ops against a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv;
    import hilo_pkg::*;

`ifdef HILO_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int          n_checks;
    int          n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    bit          m_dbz;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        bit          exp_dbz;
    } vec_t;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one request, from plain 64-bit arithmetic.
    task automatic ref_model(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                             output logic [31:0] e_hi, output logic [31:0] e_lo,
                             output bit e_dbz, output bit e_run);
        logic [63:0] p;
        longint      sq;
        longint      sr;
        e_hi  = m_hi;
        e_lo  = m_lo;
        e_dbz = m_dbz;
        e_run = 1'b0;
        case (t_op)
            3'd0: begin
                p = {32'd0, t_a} * {32'd0, t_b};
                e_hi = p[63:32]; e_lo = p[31:0]; e_run = 1'b1; e_dbz = 1'b0;
            end
            3'd1: begin
                p = longint'($signed(t_a)) * longint'($signed(t_b));
                e_hi = p[63:32]; e_lo = p[31:0]; e_run = 1'b1; e_dbz = 1'b0;
            end
            3'd2, 3'd3: begin
                if (c_DIV_EN) begin
                    e_run = 1'b1;
                    e_dbz = (t_b == 32'd0);
                    if (t_b == 32'd0) begin
                        e_hi = t_a; e_lo = 32'hFFFF_FFFF;
                    end else if (t_op == 3'd2) begin
                        e_lo = t_a / t_b; e_hi = t_a % t_b;
                    end else begin
                        sq = longint'($signed(t_a)) / longint'($signed(t_b));
                        sr = longint'($signed(t_a)) % longint'($signed(t_b));
                        e_lo = sq[31:0]; e_hi = sr[31:0];
                    end
                end
            end
            3'd4: e_hi = t_a;
            3'd5: e_lo = t_a;
            default: ;
        endcase
    endtask

    // Issue one request in the current cycle and check its full outcome.
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input bit e_dbz, input bit e_run, input string name);
        int cyc;
        int busy_cnt;
        bit got_done;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (e_run) begin
            check({name, " done_low_at_accept"}, {63'd0, done}, 64'd0);
            cyc = 0; busy_cnt = 0; got_done = 1'b0;
            while (!got_done && cyc < 60) begin
                if (busy) busy_cnt++;
                @(posedge clk); #1;
                cyc++;
                got_done = done;
            end
            check({name, " latency"}, 64'(cyc), 64'd33);
            check({name, " busy_cycles"}, 64'(busy_cnt), 64'd33);
            check({name, " busy_low_at_done"}, {63'd0, busy}, 64'd0);
            check({name, " hi"}, {32'd0, hi}, {32'd0, e_hi});
            check({name, " lo"}, {32'd0, lo}, {32'd0, e_lo});
            check({name, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, e_dbz});
            m_dbz = e_dbz;
        end else begin
            check({name, " busy_idle"}, {63'd0, busy}, 64'd0);
            check({name, " done_idle"}, {63'd0, done}, 64'd0);
            check({name, " hi"}, {32'd0, hi}, {32'd0, e_hi});
            check({name, " lo"}, {32'd0, lo}, {32'd0, e_lo});
        end
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] eh;
        logic [31:0] el;
        bit          ed;
        bit          er;
        bit          done_seen;
        logic [2:0]  r_op;
        logic [31:0] ra;
        logic [31:0] rb;
        int          wait_cnt;

        n_checks = 0; n_errors = 0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;

        vecs.push_back('{HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        vecs.push_back('{HILO_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
        vecs.push_back('{HILO_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{HILO_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
        vecs.push_back('{HILO_MULTU, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{HILO_MULT,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0});
`ifdef HILO_DIV_EN
        vecs.push_back('{HILO_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{HILO_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0});
        vecs.push_back('{HILO_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{HILO_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
        vecs.push_back('{HILO_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{HILO_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset div_by_zero", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   vecs[i].exp_dbz, 1'b1, $sformatf("vec%0d", i));

        if (!c_DIV_EN)
            run_op(HILO_DIVU, 32'd100, 32'd7, m_hi, m_lo, 1'b0, 1'b0, "divu_disabled");

        // Start while busy must be dropped, not queued.
        @(negedge clk);
        op = HILO_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = HILO_MTHI; a = 32'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start busy", {63'd0, busy}, 64'd1);
        check("ignored_start hi_untouched", {32'd0, hi}, {32'd0, m_hi});
        wait_cnt = 0;
        while (!done && wait_cnt < 60) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("ignored_start done_seen", {63'd0, done}, 64'd1);
        check("ignored_start hi", {32'd0, hi}, 64'd0);
        check("ignored_start lo", {32'd0, lo}, 64'd12);
        m_hi = 32'd0; m_lo = 32'd12;
        run_op(HILO_MTHI, 32'h1234, 32'd0, 32'h1234, 32'd12, 1'b0, 1'b0, "mthi_idle");
        run_op(HILO_MTLO, 32'hCAFE_F00D, 32'd0, 32'h1234, 32'hCAFE_F00D, 1'b0, 1'b0, "mtlo_idle");
        run_op(3'b110, 32'h5555_5555, 32'd1, 32'h1234, 32'hCAFE_F00D, 1'b0, 1'b0, "noop");

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        op = HILO_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        done_seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) done_seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) done_seen = 1'b1;
        end
        check("abort no_done", {63'd0, done_seen}, 64'd0);
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        run_op(HILO_MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 1'b1, "after_reset");

        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = rb >> $urandom_range(1, 31);
                default: ;
            endcase
            ref_model(r_op, ra, rb, eh, el, ed, er);
            run_op(r_op, ra, rb, eh, el, ed, er, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
